pipeline_return_buffer: RTL
===========================

// Module: pipeline_return_buffer
// PURPOSE
//  Receiving end of a fixed-latency, non-stallable pipeline_registers chain. It captures valid-tagged results
//  leaving the pipe into a FIFO and presents them downstream as ready/valid. Credit accounting gates issue into the pipe,
//  so a result can never arrive to a full buffer. Sits between the last pipe stage and any backpressuring consumer.
// PARAMETERS
//  BIT_WIDTH     10  width of data word returned by the pipeline
//  DEPTH          8  FIFO entries = total credits; legal 1..256; full throughput needs DEPTH >= pipe latency + 1
//  CNT_W          4  width of occupancy/credit counters; must equal $clog2(DEPTH+1)
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high reset
//  issue_ready  out  1          credit available; upstream may launch into pipe this cycle
//  issue_valid  in   1          upstream launches one item into pipe this cycle
//  ret_valid    in   1          pipe output word valid this cycle (valid bit carried down the pipe)
//  ret_data     in   BIT_WIDTH  pipe output word
//  out_valid    out  1          out_data holds FIFO head
//  out_ready    in   1          consumer accepts head this cycle
//  out_data     out  BIT_WIDTH  FIFO head word
//  occupancy    out  CNT_W      words currently stored in FIFO
//  issue_err    out  1          sticky: issue_valid seen while issue_ready=0
//  ret_err      out  1          sticky: ret_valid seen with zero items in flight
// BEHAVIOUR
//  Reset (async assert, sync release): credits=DEPTH, in_flight=0, FIFO empty, rd/wr ptr=0; outputs issue_ready=1,
//   out_valid=0, out_data=0, occupancy=0, issue_err=0, ret_err=0. Reset mid-operation discards all stored and in-flight
//   state; the pipe shares the same reset.
//  Events per cycle: ISS = issue_valid&issue_ready; RET = ret_valid&(in_flight!=0); POP = out_valid&out_ready.
//  credits: -1 on ISS, +1 on POP; both in same cycle -> unchanged. issue_ready = (credits!=0), decoded from register only
//   (no combinational path from issue_valid/out_ready).
//  in_flight: +1 on ISS, -1 on RET; both -> unchanged. Never exceeds DEPTH.
//  FIFO: circular buffer, DEPTH entries; pointers wrap DEPTH-1 -> 0 (DEPTH need not be a power of 2).
//   RET writes ret_data at wr_ptr; POP advances rd_ptr.
//   Push and pop in the same cycle are legal at any occupancy, including full; occupancy unchanged.
//   No bypass: a word written at edge N gives out_valid=1 from cycle N+1 onward. Min latency ret_valid -> out_valid = 1 clk.
//   out_data = mem[rd_ptr] when out_valid, else holds last value (0 after reset).
//   out_valid/out_data stable while out_valid=1 and out_ready=0.
//  Invariant: credits + in_flight + occupancy == DEPTH at all times; RET therefore never meets a full FIFO.
//  Errors:
//   issue_valid while issue_ready=0 -> ignored (no count change); issue_err set.
//   ret_valid while in_flight==0 -> word dropped; ret_err set.
//   Both error flags clear only on reset.
//  Ordering: strict FIFO; words leave in pipe arrival order.
// TESTING
//  1 Reset: assert reset 3 clk -> issue_ready=1, out_valid=0, occupancy=0, errs=0.
//    Release -> issue_ready=1 on first cycle.
//  2 Stream: DEPTH=8, pipe latency 4, out_ready=1, issue 20 words 0..19 back-to-back ->
//    out_data 0..19 in order, one per clk; issue_ready never drops.
//  3 Backpressure: out_ready=0, issue continuously -> issue_ready=0 after 8th issue;
//    occupancy reaches 8 after latency; raise out_ready -> 8 words drain; issue_ready=1 the cycle after first POP.
//  4 Full simultaneous: occupancy=7, in_flight=1, pulse RET and POP same clk -> occupancy stays 7; no data lost.
//  5 Errors: force ret_valid with in_flight=0 -> ret_err=1, occupancy unchanged.
//    Issue with issue_ready=0 -> issue_err=1, credits unchanged.
//  6 Mid-op reset: 5 stored, 3 in flight, pulse reset 1 clk -> all outputs at reset values; next stream correct from word 0.

Source files
------------

// File: rtl/pipeline_return_buffer.sv
// Credit-gated return buffer at the tail of a fixed-latency, non-stallable pipe.
// Results are captured into a circular FIFO and presented downstream as ready/valid.
module pipeline_return_buffer #(
  parameter int BIT_WIDTH = 10,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 issue_ready,
  input  logic                 issue_valid,
  input  logic                 ret_valid,
  input  logic [BIT_WIDTH-1:0] ret_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 issue_err,
  output logic                 ret_err
);

  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0]     credits_q, credits_d;
  logic [CNT_W-1:0]     in_flight_q, in_flight_d;
  logic [CNT_W-1:0]     occ_q, occ_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 issue_err_q, issue_err_d;
  logic                 ret_err_q, ret_err_d;

  logic iss, ret, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign issue_ready = (credits_q != '0);
  assign out_valid   = (occ_q != '0);
  assign out_data    = out_data_q;
  assign occupancy   = occ_q;
  assign issue_err   = issue_err_q;
  assign ret_err     = ret_err_q;

  always_comb begin
    iss = issue_valid & issue_ready;
    ret = ret_valid & (in_flight_q != '0);
    pop = out_valid & out_ready;

    credits_d = credits_q;
    case ({iss, pop})
      2'b10:   credits_d = credits_q - ONE_CNT;
      2'b01:   credits_d = credits_q + ONE_CNT;
      default: credits_d = credits_q;
    endcase

    in_flight_d = in_flight_q;
    case ({iss, ret})
      2'b10:   in_flight_d = in_flight_q + ONE_CNT;
      2'b01:   in_flight_d = in_flight_q - ONE_CNT;
      default: in_flight_d = in_flight_q;
    endcase

    occ_d = occ_q;
    case ({ret, pop})
      2'b10:   occ_d = occ_q + ONE_CNT;
      2'b01:   occ_d = occ_q - ONE_CNT;
      default: occ_d = occ_q;
    endcase

    wr_ptr_d = ret ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Head for next cycle: the word being written lands there if it becomes the new head.
    out_data_d = out_data_q;
    if (occ_d != '0) begin
      if (ret && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = ret_data;
      end else begin
        out_data_d = mem[rd_ptr_d];
      end
    end

    issue_err_d = issue_err_q | (issue_valid & ~issue_ready);
    ret_err_d   = ret_err_q | (ret_valid & (in_flight_q == '0));
  end

  always_ff @(posedge clk) begin
    if (ret) begin
      mem[wr_ptr_q] <= ret_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q   <= DEPTH_CNT;
      in_flight_q <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      issue_err_q <= 1'b0;
      ret_err_q   <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      issue_err_q <= issue_err_d;
      ret_err_q   <= ret_err_d;
    end
  end

endmodule
